// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Latency counter is at least one bit wide even when MEM_LAT is 1.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - IF, D and memory-side signals of the unified memory arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [1:0]        d_width_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [1:0]        mem_width_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_width_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_width_o, stall_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_width_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_width_o, stall_o
  );
endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - D-first priority with bounded IF starvation
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic       opp_i,
  output logic [1:0] win_o    // [0] IF, [1] D
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] SAT = SW'(MAX_WAIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          force_if;

  assign force_if = (starve_q == SAT);

  always_comb begin
    win_o    = 2'b00;
    starve_d = starve_q;
    if (opp_i) begin
      if (if_req_i && (!d_req_i || force_if)) win_o[0] = 1'b1;
      else if (d_req_i)                       win_o[1] = 1'b1;
    end
    // Only a lost opportunity counts; a dropped IF request forgets its history.
    if (!if_req_i || win_o[0])      starve_d = '0;
    else if (win_o[1] && !force_if) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) starve_q <= '0;
    else        starve_q <= starve_d;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one fixed-latency memory between instruction fetch and data ports
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  unified_mem_arbiter_if.slave  bus
);
  localparam int CW = cnt_width(MEM_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              resp, opp;
  logic [1:0]        win;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] rdata;

  assign rdata = bus.mem_rdata_i;
  // Outputs are gated with the reset so nothing leaks while rst_i is held low.
  assign resp = rst_i && (state_q == ST_BUSY) && (cnt_q == '0);
  assign opp  = rst_i && ((state_q == ST_IDLE) || resp);

  mem_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (bus.if_req_i),
    .d_req_i  (bus.d_req_i),
    .opp_i    (opp),
    .win_o    (win)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    if (state_q == ST_BUSY && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    if (resp) begin
      state_d = ST_IDLE;
      owner_d = OWN_NONE;
      we_d    = 1'b0;
    end
    if (win[0]) begin
      state_d = ST_BUSY;
      cnt_d   = CNT_LOAD;
      owner_d = OWN_IF;
      we_d    = 1'b0;
    end else if (win[1]) begin
      state_d = ST_BUSY;
      cnt_d   = CNT_LOAD;
      owner_d = OWN_D;
      we_d    = bus.d_we_i;
    end
  end

  always_comb begin
    issue_addr      = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_wdata_o = '0;
    bus.mem_width_o = W_BYTE;
    if (win[0]) begin
      issue_addr      = bus.if_addr_i;
      bus.mem_width_o = W_WORD;
    end else if (win[1]) begin
      issue_addr      = bus.d_addr_i;
      bus.mem_we_o    = bus.d_we_i;
      bus.mem_wdata_o = bus.d_wdata_i;
      bus.mem_width_o = bus.d_width_i;
    end
    bus.mem_addr_o  = issue_addr;
    bus.mem_req_o   = |win;
    bus.if_gnt_o    = win[0];
    bus.d_gnt_o     = win[1];
    bus.if_rvalid_o = resp && (owner_q == OWN_IF);
    bus.d_rvalid_o  = resp && (owner_q == OWN_D);
    bus.if_rdata_o  = (resp && owner_q == OWN_IF) ? rdata : '0;
    bus.d_rdata_o   = (resp && owner_q == OWN_D && !we_q) ? rdata : '0;
    // A request being granted this cycle still stalls: its data is not back yet.
    bus.stall_o     = rst_i && (bus.if_req_i || bus.d_req_i ||
                                (state_q == ST_BUSY && !resp));
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed table and randomized model checks for unified_mem_arbiter
module tb_unified_mem_arbiter;
  localparam int LAT  = 2;
  localparam int MAXW = 4;

  typedef struct {
    logic ig, dg, irv, drv, st, mreq, mwe;
    logic [31:0] maddr, mwd, ird, drd;
    logic [1:0]  mw;
  } out_t;

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr, dwe; logic [31:0] da, dwd; logic [1:0] dw;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] p1 = 32'h0, p2 = 32'h0;
  vec_t tbl[$];

  // model state
  int   m_due = -1;
  int   mcyc = 0;
  int   m_starve = 0;
  logic m_own_if = 1'b0;
  logic [31:0] m_rd = 32'h0;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] wmask(input logic [31:0] v, input logic [1:0] w);
    case (w)
      2'b00:   return {24'h0, v[7:0]};
      2'b01:   return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] w);
    return wmask(mem.exists(a) ? mem[a] : fill(a), w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] w);
    return wmask(ref_mem.exists(a) ? ref_mem[a] : fill(a), w);
  endfunction

  // memory: samples the issue at the clock edge, data visible LAT cycles after issue
  assign bus.mem_rdata_i = p2;
  always @(posedge clk) begin
    p2 <= p1;
    if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        mem[bus.mem_addr_o] = wmask(bus.mem_wdata_o, bus.mem_width_o);
        p1 <= 32'hBAD0_5705;
      end else begin
        p1 <= mem_rd(bus.mem_addr_o, bus.mem_width_o);
      end
    end else begin
      p1 <= 32'hDEAD_BEEF;
    end
  end

  function automatic vec_t mkv(input int ir, input int ia, input int dr, input int dwe,
                               input int da, input int dwd, input int dw,
                               input int ig, input int dg, input int irv, input int drv,
                               input int st, input int rd);
    vec_t v;
    v.ir = (ir != 0); v.ia = ia; v.dr = (dr != 0); v.dwe = (dwe != 0);
    v.da = da; v.dwd = dwd; v.dw = 2'(dw);
    v.e = '{default: '0};
    v.e.ig = (ig != 0); v.e.dg = (dg != 0);
    v.e.irv = (irv != 0); v.e.drv = (drv != 0); v.e.st = (st != 0);
    v.e.mreq = v.e.ig || v.e.dg;
    if (v.e.ig) begin v.e.maddr = v.ia; v.e.mw = 2'b10; end
    if (v.e.dg) begin
      v.e.maddr = v.da; v.e.mwe = v.dwe; v.e.mwd = v.dwd; v.e.mw = v.dw;
    end
    if (v.e.irv) v.e.ird = rd;
    if (v.e.drv) v.e.drd = rd;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.if_req_i  = v.ir;  bus.if_addr_i = v.ia;
    bus.d_req_i   = v.dr;  bus.d_we_i    = v.dwe; bus.d_addr_i = v.da;
    bus.d_wdata_i = v.dwd; bus.d_width_i = v.dw;
  endtask

  task automatic cmp1(input string nm, input logic act, input logic exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic check(input out_t e);
    n_vec++;
    cmp1 ("if_gnt",    bus.if_gnt_o,    e.ig);
    cmp1 ("d_gnt",     bus.d_gnt_o,     e.dg);
    cmp1 ("if_rvalid", bus.if_rvalid_o, e.irv);
    cmp1 ("d_rvalid",  bus.d_rvalid_o,  e.drv);
    cmp1 ("stall",     bus.stall_o,     e.st);
    cmp1 ("mem_req",   bus.mem_req_o,   e.mreq);
    cmp1 ("mem_we",    bus.mem_we_o,    e.mwe);
    cmp32("mem_addr",  bus.mem_addr_o,  e.maddr);
    cmp32("mem_wdata", bus.mem_wdata_o, e.mwd);
    cmp32("mem_width", 32'(bus.mem_width_o), 32'(e.mw));
    cmp32("if_rdata",  bus.if_rdata_o,  e.ird);
    cmp32("d_rdata",   bus.d_rdata_o,   e.drd);
  endtask

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    check(v.e);
    cyc++;
  endtask

  task automatic model(input vec_t v, output out_t e);
    logic busy, resp, opp, wi, wd;
    e = '{default: '0};
    busy = (m_due >= 0);
    resp = (m_due == mcyc);
    if (resp) begin
      if (m_own_if) begin e.irv = 1'b1; e.ird = m_rd; end
      else          begin e.drv = 1'b1; e.drd = m_rd; end
      m_due = -1;
    end
    opp = !busy || resp;
    wi = opp && v.ir && (!v.dr || m_starve == MAXW);
    wd = opp && v.dr && !wi;
    if (wi) begin
      e.ig = 1'b1; e.mreq = 1'b1; e.maddr = v.ia; e.mw = 2'b10;
      m_rd = ref_rd(v.ia, 2'b10); m_own_if = 1'b1; m_due = mcyc + LAT;
    end
    if (wd) begin
      e.dg = 1'b1; e.mreq = 1'b1; e.mwe = v.dwe; e.maddr = v.da; e.mwd = v.dwd; e.mw = v.dw;
      m_own_if = 1'b0; m_due = mcyc + LAT;
      if (v.dwe) begin ref_mem[v.da] = wmask(v.dwd, v.dw); m_rd = 32'h0; end
      else m_rd = ref_rd(v.da, v.dw);
    end
    if (!v.ir || wi) m_starve = 0;
    else if (wd && m_starve < MAXW) m_starve++;
    e.st = v.ir || v.dr || (busy && !resp);
    mcyc++;
  endtask

  initial begin
    out_t zero;
    vec_t idle, cur;
    out_t e;
    logic last_ig, last_dg;
    zero = '{default: '0};
    idle = mkv(0,0,0,0,0,0,0, 0,0,0,0,0,0);

    // 1: single fetch
    add(mkv(1,'h10,0,0,0,0,0, 1,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,    0,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,    0,0,1,0,0,fill('h10)));
    add(idle);
    // 2: tie goes to D, IF follows at the response cycle
    add(mkv(1,'h20,1,0,'h100,0,2, 0,1,0,0,1,0));
    add(mkv(1,'h20,0,0,0,0,0,     0,0,0,0,1,0));
    add(mkv(1,'h20,0,0,0,0,0,     1,0,0,1,1,fill('h100)));
    add(mkv(0,0,0,0,0,0,0,        0,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,        0,0,1,0,0,fill('h20)));
    add(idle);
    // 3: continuous contention, IF forced in after MAX_WAIT losses
    for (int k = 0; k <= 10; k++) begin
      int ig, dg, irv, drv, rd;
      ig  = (k == 8) ? 1 : 0;
      dg  = (k % 2 == 0 && k != 8) ? 1 : 0;
      drv = (k >= 2 && k <= 8 && k % 2 == 0) ? 1 : 0;
      irv = (k == 10) ? 1 : 0;
      rd  = irv ? fill('h40) : (drv ? fill('h200) : 0);
      add(mkv(1,'h40,1,0,'h200,0,2, ig,dg,irv,drv,1,rd));
    end
    add(mkv(0,0,0,0,0,0,0, 0,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0, 0,0,0,1,0,fill('h200)));
    add(idle);
    // 4: byte store then byte load of the same address
    add(mkv(0,0,1,1,'h3,'hAB,0, 0,1,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,      0,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,      0,0,0,1,0,0));
    add(mkv(0,0,1,0,'h3,0,0,    0,1,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,      0,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,      0,0,0,1,0,'hAB));
    // 6: D drops its request after grant, IF arrives a cycle later
    add(mkv(0,0,1,0,'h300,0,2, 0,1,0,0,1,0));
    add(mkv(1,'h60,0,0,0,0,0,  0,0,0,0,1,0));
    add(mkv(1,'h60,0,0,0,0,0,  1,0,0,1,1,fill('h300)));
    add(mkv(0,0,0,0,0,0,0,     0,0,0,0,1,0));
    add(mkv(0,0,0,0,0,0,0,     0,0,1,0,0,fill('h60)));
    add(idle);

    // reset state, with requests pending
    drive(mkv(1,'h70,1,0,'h80,0,2, 0,0,0,0,0,0));
    repeat (3) begin
      @(negedge clk);
      check(zero);
    end
    @(posedge clk); #1;
    drive(idle);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // 5: reset while a fetch is in flight
    step(mkv(1,'h50,0,0,0,0,0, 1,0,0,0,1,0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check(zero);
    cyc++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check(mkv(1,'h50,0,0,0,0,0, 1,0,0,0,1,0).e);
    cyc++;
    step(mkv(0,0,0,0,0,0,0, 0,0,0,0,1,0));
    step(mkv(0,0,0,0,0,0,0, 0,0,1,0,0,fill('h50)));
    step(idle);

    // randomized traffic against the transaction-level model
    ref_mem = mem;
    cur = idle;
    last_ig = 1'b0;
    last_dg = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!cur.ir || last_ig) begin
        cur.ir = ($urandom_range(0, 2) != 0);
        cur.ia = 32'($urandom_range(0, 31)) << 2;
      end else if ($urandom_range(0, 19) == 0) begin
        cur.ir = 1'b0;
      end
      if (!cur.dr || last_dg) begin
        cur.dr  = ($urandom_range(0, 3) != 0);
        cur.dwe = ($urandom_range(0, 1) != 0);
        cur.da  = (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
        cur.dwd = $urandom;
        cur.dw  = 2'($urandom_range(0, 2));
      end else if ($urandom_range(0, 19) == 0) begin
        cur.dr = 1'b0;
      end
      @(posedge clk); #1;
      drive(cur);
      model(cur, e);
      @(negedge clk);
      check(e);
      cyc++;
      last_ig = e.ig;
      last_dg = e.dg;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
